i2s_tdm_rx: RTL
===============

// Module: i2s_tdm_rx
// PURPOSE
//  Multi-channel serial-audio receiver; successor to the two-channel i2s_rx.
//  Deserialises NUM_CH slots per frame from sdata using the bclk_falling strobe and lrclk from i2s_clkgen.
//  Supports I2S (1-bit delay) and left-justified framing.
//  Delivers {channel, sample} words through a FIFO with a valid/ready stream to the FFT front end.
// PARAMETERS
//  NUM_CH      2   channels (slots) per frame, 2..8
//  SLOT_BITS   32  bit clocks per slot
//  DATA_BITS   24  sample bits per slot, MSB first; DATA_BITS+DELAY <= SLOT_BITS
//  DELAY       1   frame-edge to channel-0 MSB, in bits: 1 = I2S, 0 = left-justified
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >= 2
// PORTS
//  clk           in   1          system clock; single clock domain
//  rst           in   1          synchronous reset, active-high
//  bclk_falling  in   1          one-clk strobe; sdata and lrclk are sampled only when it is high
//  lrclk         in   1          frame sync; a 1->0 transition seen across two strobes marks a frame edge
//  sdata         in   1          serial data
//  out_data      out  DATA_BITS  sample, MSB-first as received
//  out_ch        out  CH_W       slot index, 0..NUM_CH-1; CH_W = max(1, $clog2(NUM_CH))
//  out_last      out  1          high when out_ch == NUM_CH-1
//  out_valid     out  1          FIFO head valid
//  out_ready     in   1          consumer accepts head when out_valid && out_ready
//  locked        out  1          high once the first frame edge has been seen
//  frame_err     out  1          one-clk pulse: short frame detected
//  overrun       out  1          sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset
//   - All outputs 0; FIFO empty; state UNSYNC; bit position pos = 0; previous lrclk register = 1.
//   - Reset mid-frame discards any partial word and any FIFO contents.
//  Frame edge
//   - Detected at a strobe where lrclk == 0 and the lrclk sampled at the previous strobe == 1.
//   - The bit sampled at that strobe has pos = 0; pos increments by 1 per strobe.
//   - pos saturates at NUM_CH*SLOT_BITS.
//  States
//   - UNSYNC: ignore sdata. On a frame edge, set locked = 1 and go to CAPTURE at pos 0.
//   - CAPTURE: slot c = pos / SLOT_BITS; offset o = pos % SLOT_BITS.
//       DELAY <= o < DELAY+DATA_BITS: shift sdata in, MSB first.
//       o == DELAY+DATA_BITS-1: the word for slot c is complete.
//       Bits at other offsets are ignored.
//       When pos reaches NUM_CH*SLOT_BITS, go to WAIT.
//   - WAIT: ignore sdata until the next frame edge, then return to CAPTURE at pos 0.
//       A longer-than-nominal frame is not an error.
//  Short frame
//   - A frame edge in CAPTURE with pos < NUM_CH*SLOT_BITS:
//       pulse frame_err for one clk;
//       discard the partial word (completed slots already queued are kept);
//       restart at pos 0 using the edge bit.
//  Cycles with no strobe
//   - No state change; a strobe is never missed.
//  Latency
//   - Completion strobe at cycle N: the word is written to the FIFO at N+1.
//   - out_valid rises at N+2 if the FIFO was empty.
//   - out_data, out_ch and out_last stay stable while out_valid && !out_ready.
//  FIFO
//   - Push and pop in the same cycle are both performed, including when the FIFO is full.
//   - Push when full with no pop: drop the new word and set overrun = 1, held until rst.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - Throughput: one word per SLOT_BITS strobes is far below the FIFO rate, so at most 1 push per clk.
//  lrclk
//   - May change at any strobe.
//   - Only the 1->0 transition is significant; 0->1 has no effect (pure slot counting).
// TESTING
//  1. NUM_CH=2, DELAY=1, SLOT_BITS=32, out_ready=1; loopback i2s_tx with L=24'hA5A5A5, R=24'h123456
//     -> words {0,A5A5A5,last=0} then {1,123456,last=1}, repeating every frame.
//  2. NUM_CH=4, DELAY=0, SLOT_BITS=32, bit-level driver sending slots 0x111111/0x222222/0x333333/0x444444
//     -> out_ch 0..3 in order with matching data; out_last only on ch3.
//  3. Bytes on sdata before the first lrclk 1->0 edge
//     -> no words and locked=0; locked rises at the first edge strobe.
//  4. Frame edge at pos 40 (mid slot 1, NUM_CH=2)
//     -> ch0 word delivered; ch1 partial discarded; frame_err pulses once; next frame decodes correctly.
//  5. out_ready=0 for 3 frames with FIFO_DEPTH=4, NUM_CH=2
//     -> first 4 words held with stable outputs; overrun=1; after release the 4 oldest words drain in order.
//  6. rst pulsed mid-slot then released
//     -> all outputs 0 and out_valid=0; waits for a fresh frame edge; first word out is from a complete slot.

Source files
------------

// File: rtl/i2s_tdm_rx.sv
// i2s_tdm_rx: multi-slot I2S / left-justified serial-audio receiver delivering
// {channel, sample} words through a small valid/ready FIFO.
module i2s_tdm_rx #(
   parameter int  NUM_CH     = 2,
   parameter int  SLOT_BITS  = 32,
   parameter int  DATA_BITS  = 24,
   parameter int  DELAY      = 1,
   parameter int  FIFO_DEPTH = 4,
   localparam int CH_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bclk_falling,
   input  logic                 lrclk,
   input  logic                 sdata,
   output logic [DATA_BITS-1:0] out_data,
   output logic [CH_W-1:0]      out_ch,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 locked,
   output logic                 frame_err,
   output logic                 overrun
);
   localparam int OFF_W  = $clog2(SLOT_BITS);
   localparam int SLOT_W = $clog2(NUM_CH + 1);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int W      = CH_W + DATA_BITS;
   localparam logic [OFF_W-1:0]  OFF_FIRST = OFF_W'(DELAY);
   localparam logic [OFF_W-1:0]  REL_LAST  = OFF_W'(DATA_BITS - 1);
   localparam logic [OFF_W-1:0]  OFF_END   = OFF_W'(SLOT_BITS - 1);
   localparam logic [SLOT_W-1:0] SLOT_END  = SLOT_W'(NUM_CH);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [AW:0]       CNT_FULL  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_UNSYNC, S_CAPTURE, S_WAIT} state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_prev_lr;
   logic [OFF_W-1:0]     r_off;
   logic [SLOT_W-1:0]    r_slot;
   logic [DATA_BITS-2:0] r_shift;
   logic                 r_locked;
   logic                 r_frame_err;
   logic                 r_push;
   logic [W-1:0]         r_push_word;
   logic [W-1:0]         r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wptr, r_rptr;
   logic [AW:0]          r_count;
   logic                 r_overrun;

   logic                 w_edge, w_run, w_in_data, w_done, w_wrap, w_ferr;
   logic [OFF_W-1:0]     w_off, w_rel, w_off_nxt;
   logic [SLOT_W-1:0]    w_slot, w_slot_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_valid, w_pop, w_full, w_wr;
   logic [W-1:0]         w_head;

   // A frame edge forces the current bit to position 0, whatever was counted before.
   assign w_edge      = bclk_falling && !lrclk && r_prev_lr;
   assign w_run       = w_edge || (bclk_falling && r_state == S_CAPTURE);
   assign w_off       = w_edge ? '0 : r_off;
   assign w_slot      = w_edge ? '0 : r_slot;
   assign w_rel       = w_off - OFF_FIRST;
   assign w_in_data   = w_rel <= REL_LAST;
   assign w_done      = w_run && w_rel == REL_LAST;
   assign w_wrap      = w_off == OFF_END;
   assign w_off_nxt   = w_wrap ? '0 : w_off + OFF_W'(1);
   assign w_slot_nxt  = w_wrap ? w_slot + SLOT_W'(1) : w_slot;
   assign w_shift_nxt = {r_shift, sdata};
   assign w_ferr      = w_edge && r_state == S_CAPTURE;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_UNSYNC;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_run) w_state_nxt = (w_slot_nxt == SLOT_END) ? S_WAIT : S_CAPTURE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_lr   <= 1'b1;
         r_off       <= '0;
         r_slot      <= '0;
         r_shift     <= '0;
         r_locked    <= 1'b0;
         r_frame_err <= 1'b0;
         r_push      <= 1'b0;
         r_push_word <= '0;
      end else begin
         r_frame_err <= w_ferr;
         r_push      <= w_done;
         if (bclk_falling) r_prev_lr <= lrclk;
         if (w_edge) r_locked <= 1'b1;
         if (w_run) begin
            r_off  <= w_off_nxt;
            r_slot <= w_slot_nxt;
         end
         if (w_run && w_in_data) r_shift <= w_shift_nxt[DATA_BITS-2:0];
         if (w_done) r_push_word <= {w_slot[CH_W-1:0], w_shift_nxt};
      end
   end

   // When full, a simultaneous pop frees the head slot that the write pointer lands on.
   assign w_valid = r_count != '0;
   assign w_pop   = w_valid && out_ready;
   assign w_full  = r_count == CNT_FULL;
   assign w_wr    = r_push && (!w_full || w_pop);
   assign w_head  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
         if (r_push && w_full && !w_pop) r_overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= r_push_word;
   end

   assign out_valid = w_valid;
   assign out_data  = w_valid ? w_head[DATA_BITS-1:0] : '0;
   assign out_ch    = w_valid ? w_head[W-1:DATA_BITS] : '0;
   assign out_last  = w_valid && w_head[W-1:DATA_BITS] == CH_LAST;
   assign locked    = r_locked;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
endmodule
